// File: rtl/playback_timer_pkg.sv
// Shared player-state encodings and mm:ss BCD time type for the playback timer
// and the state display stage.
package playback_timer_pkg;

  typedef enum logic [1:0] {
    StStop  = 2'd0,
    StPlay  = 2'd1,
    StPause = 2'd2
  } player_state_e;

  // Field order matches the track_len port: {min tens, min units, sec tens, sec units}.
  typedef struct packed {
    logic [3:0] min_tens;
    logic [3:0] min_units;
    logic [3:0] sec_tens;
    logic [3:0] sec_units;
  } bcd_time_t;

  // One-second increment with carries; 99:59 wraps to 00:00.
  function automatic bcd_time_t bcd_time_inc(bcd_time_t t);
    bcd_time_t n;
    n = t;
    if (t.sec_units == 4'd9) begin
      n.sec_units = 4'd0;
      if (t.sec_tens == 4'd5) begin
        n.sec_tens = 4'd0;
        if (t.min_units == 4'd9) begin
          n.min_units = 4'd0;
          n.min_tens  = (t.min_tens == 4'd9) ? 4'd0 : t.min_tens + 4'd1;
        end else begin
          n.min_units = t.min_units + 4'd1;
        end
      end else begin
        n.sec_tens = t.sec_tens + 4'd1;
      end
    end else begin
      n.sec_units = t.sec_units + 4'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/bcd_time_counter.sv
// mm:ss BCD elapsed-time counter; also exposes the value it would take on the
// next increment so the parent can detect track end on the same edge.
module bcd_time_counter
  import playback_timer_pkg::*;
(
  input  logic      clock,
  input  logic      reset,
  input  logic      clear,
  input  logic      inc,
  output bcd_time_t time_o,
  output bcd_time_t time_next_o
);

  bcd_time_t time_q, time_d, time_inc;

  always_comb begin
    time_inc = bcd_time_inc(time_q);
    time_d   = time_q;
    if (clear) begin
      time_d = '0;
    end else if (inc) begin
      time_d = time_inc;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      time_q <= '0;
    end else begin
      time_q <= time_d;
    end
  end

  assign time_o      = time_q;
  assign time_next_o = time_inc;

endmodule

// File: rtl/playback_timer.sv
// Play/pause/stop player FSM with a one-second prescaler, mm:ss elapsed time
// and a one-cycle track_done pulse when the configured track length is reached.
module playback_timer
  import playback_timer_pkg::*;
#(
  parameter int unsigned CLKS_PER_SEC = 100_000_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        play_pause,
  input  logic        stop,
  input  logic [15:0] track_len,
  output logic [1:0]  state,
  output logic [3:0]  BCD3,
  output logic [3:0]  BCD2,
  output logic [3:0]  BCD1,
  output logic [3:0]  BCD0,
  output logic        track_done
);

  localparam int unsigned PrescW = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
  localparam logic [PrescW-1:0] PrescMax = PrescW'(CLKS_PER_SEC - 1);

  logic [1:0]        state_q, state_d;
  logic [PrescW-1:0] presc_q, presc_d;
  logic              done_q, done_d;
  logic              tick, track_end, cnt_clear, cnt_inc;
  bcd_time_t         time_q, time_next;

  assign tick      = (state_q == StPlay) && (presc_q == PrescMax);
  assign track_end = tick && (track_len != 16'h0000) && (time_next == track_len);
  // stop discards a coincident tick; track end restarts from 00:00.
  assign cnt_clear = stop || track_end;
  assign cnt_inc   = tick && !stop;

  bcd_time_counter u_time (
    .clock       (clock),
    .reset       (reset),
    .clear       (cnt_clear),
    .inc         (cnt_inc),
    .time_o      (time_q),
    .time_next_o (time_next)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StStop;
      presc_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    if (stop) begin
      state_d = StStop;
      presc_d = '0;
    end else begin
      case (state_q)
        StStop: begin
          presc_d = '0;
          if (play_pause) state_d = StPlay;
        end
        StPlay: begin
          presc_d = tick ? '0 : presc_q + 1'b1;
          if (track_end) begin
            state_d = StStop;
          end else if (play_pause) begin
            state_d = StPause;
          end
        end
        StPause: begin
          if (play_pause) state_d = StPlay;
        end
        default: begin
          state_d = StStop;
          presc_d = '0;
        end
      endcase
    end
    done_d = track_end && !stop;
  end

  always_comb begin
    state                    = state_q;
    {BCD3, BCD2, BCD1, BCD0} = time_q;
    track_done               = done_q;
  end

endmodule

// File: tb/tb_playback_timer.sv
// Self-checking bench for playback_timer against an elapsed-seconds reference model.
module tb_playback_timer;

  localparam int unsigned N = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        play_pause = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] track_len = 16'h0000;
  logic [1:0]  state;
  logic [3:0]  BCD3, BCD2, BCD1, BCD0;
  logic        track_done;

  int tests = 0;
  int fails = 0;

  // Model: player state, whole seconds elapsed, play cycles into the current second.
  int m_state, m_secs, m_frac;
  bit m_done;

  always #5 clock = ~clock;

  playback_timer #(.CLKS_PER_SEC(N)) dut (
    .clock      (clock),
    .reset      (reset),
    .play_pause (play_pause),
    .stop       (stop),
    .track_len  (track_len),
    .state      (state),
    .BCD3       (BCD3),
    .BCD2       (BCD2),
    .BCD1       (BCD1),
    .BCD0       (BCD0),
    .track_done (track_done)
  );

  function automatic logic [15:0] to_bcd(int s);
    int mi, se;
    mi = s / 60;
    se = s % 60;
    return {4'(mi / 10), 4'(mi % 10), 4'(se / 10), 4'(se % 10)};
  endfunction

  function automatic logic [18:0] exp_vec();
    return {2'(m_state), to_bcd(m_secs), m_done};
  endfunction

  function automatic logic [18:0] dut_vec();
    return {state, BCD3, BCD2, BCD1, BCD0, track_done};
  endfunction

  task automatic model_reset();
    m_state = 0; m_secs = 0; m_frac = 0; m_done = 0;
  endtask

  task automatic model_step(bit pp, bit st, logic [15:0] tl);
    int nsec;
    m_done = 0;
    if (st) begin
      m_state = 0; m_secs = 0; m_frac = 0;
    end else if (m_state == 1) begin
      m_frac++;
      if (m_frac == N) begin
        m_frac = 0;
        nsec = (m_secs + 1) % 6000;
        if (tl != 16'h0000 && to_bcd(nsec) == tl) begin
          m_state = 0; m_secs = 0; m_done = 1;
        end else begin
          m_secs = nsec;
          if (pp) m_state = 2;
        end
      end else if (pp) begin
        m_state = 2;
      end
    end else if (m_state == 2) begin
      if (pp) m_state = 1;
    end else begin
      m_frac = 0;
      if (pp) m_state = 1;
    end
  endtask

  // Called at posedge+1; returns at the following posedge+1.
  task automatic step(bit pp, bit st);
    play_pause = pp;
    stop       = st;
    @(posedge clock);
    model_step(pp, st, track_len);
    #1;
    play_pause = 1'b0;
    stop       = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    tests++;
    if (dut_vec() !== 19'd0) begin
      fails++; $display("FAIL reset_outputs: got %h want %h", dut_vec(), 19'd0);
    end
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    model_step(0, 0, track_len);
    #1;
    tests++;
    if (dut_vec() !== exp_vec()) begin
      fails++; $display("FAIL reset_release: got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_play_basic();
    track_len = 16'h0000;
    step(1, 0);
    tests++;
    if (state !== 2'd1) begin
      fails++; $display("FAIL play_state: got %0d want 1", state);
    end
    for (int i = 1; i <= 8; i++) begin
      step(0, 0);
      tests++;
      if (dut_vec() !== exp_vec()) begin
        fails++; $display("FAIL play_cycle%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
      if (i == 4 || i == 8) begin
        tests++;
        if (BCD0 !== 4'(i / 4)) begin
          fails++; $display("FAIL play_bcd0_c%0d: got %0d want %0d", i, BCD0, i / 4);
        end
      end
    end
  endtask

  task automatic test_pause_resume();
    step(0, 1);
    step(1, 0);
    repeat (N) step(0, 0);
    step(0, 0);
    step(1, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 0);
      tests++;
      if (state !== 2'd2 || {BCD1, BCD0} !== 8'h01) begin
        fails++; $display("FAIL pause_hold%0d: got st=%0d t=%h want st=2 t=01", i, state,
                          {BCD1, BCD0});
      end
    end
    step(1, 0);
    step(0, 0);
    tests++;
    if (state !== 2'd1 || BCD0 !== 4'd1) begin
      fails++; $display("FAIL resume_early: got st=%0d s=%0d want st=1 s=1", state, BCD0);
    end
    step(0, 0);
    tests++;
    if (BCD0 !== 4'd2 || dut_vec() !== exp_vec()) begin
      fails++; $display("FAIL resume_tick: got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_carries();
    logic [15:0] want;
    step(0, 1);
    track_len = 16'h0000;
    step(1, 0);
    for (int s = 1; s <= 6000; s++) begin
      repeat (N) step(0, 0);
      if (s == 60 || s == 600 || s == 5999 || s == 6000) begin
        want = (s == 60) ? 16'h0100 : (s == 600) ? 16'h1000 : (s == 5999) ? 16'h9959 : 16'h0000;
        tests++;
        if ({BCD3, BCD2, BCD1, BCD0} !== want || dut_vec() !== exp_vec()) begin
          fails++; $display("FAIL carry_s%0d: got %h want %h", s, {BCD3, BCD2, BCD1, BCD0}, want);
        end
      end
    end
  endtask

  task automatic test_track_end();
    step(0, 1);
    track_len = 16'h0003;
    step(1, 0);
    for (int i = 1; i <= 12; i++) begin
      step(0, 0);
      tests++;
      if (dut_vec() !== exp_vec()) begin
        fails++; $display("FAIL track_cycle%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    tests++;
    if (dut_vec() !== {2'd0, 16'h0000, 1'b1}) begin
      fails++; $display("FAIL track_end: got %h want %h", dut_vec(), {2'd0, 16'h0000, 1'b1});
    end
    step(0, 0);
    tests++;
    if (track_done !== 1'b0) begin
      fails++; $display("FAIL track_done_width: got %0d want 0", track_done);
    end
    track_len = 16'h0000;
  endtask

  task automatic test_stop_coincide();
    step(0, 1);
    step(1, 0);
    step(1, 1);
    tests++;
    if (dut_vec() !== 19'd0) begin
      fails++; $display("FAIL stop_with_pp: got %h want 0", dut_vec());
    end
    step(1, 0);
    repeat (N - 1) step(0, 0);
    step(1, 1);
    tests++;
    if (dut_vec() !== 19'd0 || dut_vec() !== exp_vec()) begin
      fails++; $display("FAIL stop_with_tick: got %h want 0", dut_vec());
    end
  endtask

  task automatic test_back_to_back();
    step(0, 1);
    track_len = 16'h0000;
    step(1, 0);
    repeat (N - 1) step(0, 0);
    step(1, 0);
    tests++;
    if (dut_vec() !== {2'd2, 16'h0001, 1'b0}) begin
      fails++; $display("FAIL tick_with_pause: got %h want %h", dut_vec(), {2'd2, 16'h0001, 1'b0});
    end
    track_len = 16'h0002;
    step(1, 0);
    repeat (N - 1) step(0, 0);
    step(1, 0);
    tests++;
    if (dut_vec() !== {2'd0, 16'h0000, 1'b1} || dut_vec() !== exp_vec()) begin
      fails++; $display("FAIL end_with_pp: got %h want %h", dut_vec(), {2'd0, 16'h0000, 1'b1});
    end
    track_len = 16'h0000;
  endtask

  task automatic test_async_reset();
    step(0, 1);
    step(1, 0);
    repeat (7 * N) step(0, 0);
    tests++;
    if (dut_vec() !== {2'd1, 16'h0007, 1'b0}) begin
      fails++; $display("FAIL pre_reset: got %h want %h", dut_vec(), {2'd1, 16'h0007, 1'b0});
    end
    #2 reset = 1'b1;
    #1;
    model_reset();
    tests++;
    if (dut_vec() !== 19'd0) begin
      fails++; $display("FAIL async_reset: got %h want 0", dut_vec());
    end
    #2 reset = 1'b0;
    @(posedge clock);
    model_step(0, 0, track_len);
    #1;
    tests++;
    if (dut_vec() !== exp_vec()) begin
      fails++; $display("FAIL after_reset: got %h want %h", dut_vec(), exp_vec());
    end
    step(1, 0);
    force dut.state_q = 2'd3;
    #1;
    release dut.state_q;
    @(posedge clock);
    m_state = 0;
    m_frac  = 0;
    #1;
    tests++;
    if (state !== 2'd0 || dut_vec() !== exp_vec()) begin
      fails++; $display("FAIL illegal_state: got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    logic [15:0] lens [6];
    bit pp, st;
    lens = '{16'h0000, 16'h0002, 16'h0005, 16'h0010, 16'h00A0, 16'h0007};
    step(0, 1);
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 15) == 0) track_len = lens[$urandom_range(0, 5)];
      pp = ($urandom_range(0, 7) == 0);
      st = ($urandom_range(0, 39) == 0);
      step(pp, st);
      tests++;
      if (dut_vec() !== exp_vec()) begin
        fails++; $display("FAIL random_c%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_play_basic();
    test_pause_resume();
    test_carries();
    test_track_end();
    test_stop_coincide();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/playback_timer.md
PLAYBACK_TIMER -- requirements
Module: playback_timer

Interface
REQ-001 Parameter: CLKS_PER_SEC, default 100_000_000, clock cycles per elapsed-time second (minimum 2).
REQ-002 Port: clock  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: play_pause  input  1  single-cycle pulse (debounced, one-pulsed upstream); toggles play/pause.
REQ-005 Port: stop  input  1  single-cycle pulse; forces STOP.
REQ-006 Port: track_len  input  16  track length, BCD {min tens, min units, sec tens, sec units}; 16'h0000 = unlimited.
REQ-007 Port: state  output  2  player state: STOP=0, PLAY=1, PAUSE=2; feeds the state display stage.
REQ-008 Port: BCD3, BCD2, BCD1, BCD0  output  4 each  elapsed time mm:ss (BCD3 = min tens … BCD0 = sec units).
REQ-009 Port: track_done  output  1  one-cycle pulse when playback reaches track_len.

Function
REQ-010 All outputs SHALL be registered; no combinational path from inputs to outputs.
REQ-011 Transitions on play_pause: STOP->PLAY, PLAY->PAUSE, PAUSE->PLAY, all effective the next cycle.
REQ-012 A stop pulse from any state SHALL cause: STOP next cycle; elapsed time = 00:00; prescaler = 0.
REQ-013 If stop and play_pause coincide, stop SHALL win.
REQ-014 State encoding 3 is illegal and SHALL be replaced by STOP on the next edge.
REQ-015 Prescaler behaviour by state:
- PLAY: counts 0..CLKS_PER_SEC-1 and wraps; the wrap cycle is a "second tick".
- PAUSE: holds its value.
- STOP: held at 0.
REQ-016 Resume after PAUSE SHALL continue from the held prescaler value, so no partial second is lost or gained.
REQ-017 Second tick increments elapsed time the same edge, with carries:
- BCD0: 9->0, carry to BCD1.
- BCD1: 5->0, carry to BCD2.
- BCD2: 9->0, carry to BCD3.
- BCD3: 9->0 (99:59 wraps to 00:00).
REQ-018 First tick after entering PLAY from STOP SHALL occur exactly CLKS_PER_SEC cycles after the state output shows PLAY.
REQ-019 Track end, when track_len != 0 and a tick would make elapsed equal track_len:
- state goes to STOP and elapsed to 00:00 on that edge;
- track_done = 1 for exactly that one following cycle.
REQ-020 track_len = 0, or a track_len never reached (including invalid BCD digits), SHALL never assert track_done; time wraps per REQ-017.
REQ-021 track_len is sampled only on the tick cycle; changing it mid-play takes effect at the next tick.
REQ-022 A tick coinciding with play_pause in PLAY SHALL apply both: time increments and state becomes PAUSE.
REQ-023 A tick coinciding with stop SHALL be discarded: time 00:00, no track_done.
REQ-024 A tick coinciding with track end and play_pause SHALL give STOP plus track_done; play_pause is ignored that cycle.
REQ-025 play_pause or stop held high multiple cycles SHALL act once per cycle high (upstream guarantees one-cycle pulses).

Reset
REQ-026 On reset assertion, immediately and independent of clock, all of the following SHALL be cleared:
- state = STOP
- BCD3..BCD0 = 0
- prescaler = 0
- track_done = 0
REQ-027 Reset asserted mid-PLAY or mid-PAUSE SHALL abandon elapsed time; first edge after deassertion behaves as from STOP.

Structure
REQ-028 STOP/PLAY/PAUSE encodings SHALL live in the shared state-constants package/header used by the display stage.
REQ-029 The mm:ss BCD counter with carry chain SHALL be one sub-module, bcd_time_counter:
- inputs: clock, reset, clear, inc;
- outputs: four BCD digits, plus next-value output for the track-end compare.

Verification (CLKS_PER_SEC=4)
REQ-030 Reset, then one play_pause pulse -> state=1; BCD0 becomes 1 four cycles later and 2 eight cycles later.
REQ-031 PLAY for 2 cycles past a tick, pause for 10, resume -> next increment exactly 2 cycles after resume; no increment while state=2.
REQ-032 Preload 00:59 via 59 ticks, one more tick -> BCD = 0,1,0,0; from 09:59 -> 1,0,0,0; from 99:59 -> 0,0,0,0.
REQ-033 track_len=16'h0003, play -> after 12 cycles of PLAY: state=0, time 00:00, track_done high exactly one cycle.
REQ-034 stop coincident with play_pause and with tick -> state=0, time 00:00, track_done=0.
REQ-035 Reset asserted between clock edges while at 00:07 PLAY -> outputs zero before next edge; force state=3 -> STOP next edge.
